// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared types and constants for the UART receive controller.
//   state_e    : receive FSM states
//   PRESC_*    : legal oversample ratios
//   DATA_W_DEF : default data bits per frame
//   EDGE_W     : width of the edge counter / prescale input
//   BIT_CNT_W  : width of the bit counter (start + data + parity + stop)
// -----------------------------------------------------------------------------
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic [5:0] PRESC_8  = 6'd8;
  localparam logic [5:0] PRESC_16 = 6'd16;
  localparam logic [5:0] PRESC_32 = 6'd32;

  localparam int DATA_W_DEF = 8;

  // Wide enough to hold the largest prescale value itself, not just prescale-1.
  localparam int EDGE_W = $clog2(int'(PRESC_32)) + 1;

  // Counts start bit, data bits, parity and stop without wrapping.
  localparam int BIT_CNT_W = $clog2(DATA_W_DEF + 3);

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// -----------------------------------------------------------------------------
// uart_rx_edge_bit_counter
// Bit-timing counters for the UART receiver. edge_cnt walks 0..presc-1 while
// run is high, then wraps and bumps bit_cnt. Both are held at zero while run is
// low (FSM in IDLE).
// Ports:
//   CLK       in   oversampling clock
//   RST       in   synchronous reset, active-high
//   run       in   FSM is inside a frame
//   presc     in   prescale latched at start detection
//   edge_cnt  out  edge index within the current bit
//   bit_cnt   out  bit index within the frame (0 = start bit)
//   eob       out  end-of-bit: last edge of the current bit
// -----------------------------------------------------------------------------
module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 run,
  input  logic [EDGE_W-1:0]    presc,
  output logic [EDGE_W-1:0]    edge_cnt,
  output logic [BIT_CNT_W-1:0] bit_cnt,
  output logic                 eob
);

  localparam logic [EDGE_W-1:0]    EDGE_ONE = 1;
  localparam logic [BIT_CNT_W-1:0] BIT_ONE  = 1;

  assign eob = run && (edge_cnt == (presc - EDGE_ONE));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge CLK) begin
    if (RST) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!run) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (eob) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + BIT_ONE;
    end else begin
      edge_cnt <= edge_cnt + EDGE_ONE;
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// -----------------------------------------------------------------------------
// uart_rx_fsm
// UART receive controller for one serial line in the oversampled RX domain.
// Detects the start bit, drives the data_sampling stage (dat_samp_en,
// edge_cnt), consumes its majority-voted sampled_bit at each end-of-bit,
// deserialises DATA_W bits LSB-first, checks optional parity and the stop bit,
// and presents good bytes on P_DATA with a one-cycle data_valid strobe.
//
// Optional feature: define UART_RX_ERR_CNT_EN to add saturating per-frame
// error counters par_err_cnt / stp_err_cnt (ERR_W bits, cleared only by RST).
//
// Ports:
//   CLK          in   oversampling clock (prescale x baud)
//   RST          in   synchronous reset, active-high
//   RX_IN        in   serial line, idle high
//   prescale     in   oversample ratio (8, 16 or 32), latched at start
//   PAR_EN       in   parity bit present, latched at start
//   PAR_TYP      in   0 = even, 1 = odd, latched at start
//   sampled_bit  in   majority-voted bit from data_sampling
//   dat_samp_en  out  enable for data_sampling (high outside IDLE)
//   edge_cnt     out  edge index within the current bit
//   P_DATA       out  last good byte
//   data_valid   out  one-cycle strobe when P_DATA is updated
//   par_err      out  parity error of the current/last frame
//   stp_err      out  stop (framing) error of the current/last frame
//   par_err_cnt  out  (UART_RX_ERR_CNT_EN) saturating parity-error count
//   stp_err_cnt  out  (UART_RX_ERR_CNT_EN) saturating stop-error count
// -----------------------------------------------------------------------------
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ERR_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RX_IN,
  input  logic [5:0]        prescale,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  input  logic              sampled_bit,
  output logic              dat_samp_en,
  output logic [5:0]        edge_cnt,
  output logic [DATA_W-1:0] P_DATA,
  output logic              data_valid,
  output logic              par_err,
  output logic              stp_err
`ifdef UART_RX_ERR_CNT_EN
  ,
  output logic [ERR_W-1:0]  par_err_cnt,
  output logic [ERR_W-1:0]  stp_err_cnt
`endif
);

  // ERR_W only sizes the optional counters; a zero width is never meaningful.
  if (ERR_W < 1) begin : g_err_w_illegal
  end

  state_e state_q, state_d;

  // Frame configuration, frozen for the whole frame at start detection.
  logic [EDGE_W-1:0] cfg_presc;
  logic              cfg_par_en;
  logic              cfg_par_typ;

  logic [DATA_W-1:0]    shift_reg;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 eob;

  // Control strobes from the FSM to the datapath.
  logic start_det;
  logic shift_en;
  logic clr_flags;
  logic chk_par;
  logic chk_stop;

  // ---------------------------------------------------------------------------
  // Bit timing
  // ---------------------------------------------------------------------------
  uart_rx_edge_bit_counter u_cnt (
    .CLK      (CLK),
    .RST      (RST),
    .run      (state_q != IDLE),
    .presc    (cfg_presc),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .eob      (eob)
  );

  assign dat_samp_en = (state_q != IDLE);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    start_det = 1'b0;
    shift_en  = 1'b0;
    clr_flags = 1'b0;
    chk_par   = 1'b0;
    chk_stop  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!RX_IN) begin
          start_det = 1'b1;
          state_d   = START;
        end
      end

      START: begin
        if (eob) begin
          // A line that is high again mid start-bit was a glitch: drop it
          // without disturbing the flags of the previous frame.
          if (sampled_bit) begin
            state_d = IDLE;
          end else begin
            clr_flags = 1'b1;
            state_d   = DATA;
          end
        end
      end

      DATA: begin
        if (eob) begin
          shift_en = 1'b1;
          // bit_cnt 0 is the start bit, so the last data bit is index DATA_W.
          if (bit_cnt == BIT_CNT_W'(DATA_W))
            state_d = cfg_par_en ? PARITY : STOP;
        end
      end

      PARITY: begin
        if (eob) begin
          chk_par = 1'b1;
          state_d = STOP;
        end
      end

      STOP: begin
        if (eob) begin
          chk_stop = 1'b1;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      cfg_presc   <= '0;
      cfg_par_en  <= 1'b0;
      cfg_par_typ <= 1'b0;
      shift_reg   <= '0;
      P_DATA      <= '0;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
    end else begin
      data_valid <= 1'b0;

      if (start_det) begin
        cfg_presc   <= prescale;
        cfg_par_en  <= PAR_EN;
        cfg_par_typ <= PAR_TYP;
      end

      // LSB arrives first, so new bits enter at the top and drift down.
      if (shift_en)
        shift_reg <= {sampled_bit, shift_reg[DATA_W-1:1]};

      if (clr_flags) begin
        par_err <= 1'b0;
        stp_err <= 1'b0;
      end

      // Even parity expects the bit to equal the data XOR; odd inverts it.
      if (chk_par)
        par_err <= (sampled_bit != ((^shift_reg) ^ cfg_par_typ));

      if (chk_stop) begin
        stp_err <= ~sampled_bit;
        // par_err was cleared at this frame's start, so it reflects this frame.
        if (sampled_bit && !par_err) begin
          P_DATA     <= shift_reg;
          data_valid <= 1'b1;
        end
      end
    end
  end

`ifdef UART_RX_ERR_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating per-frame error counters
  // ---------------------------------------------------------------------------
  localparam logic [ERR_W-1:0] ERR_ONE = 1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      par_err_cnt <= '0;
      stp_err_cnt <= '0;
    end else begin
      if (chk_par && (sampled_bit != ((^shift_reg) ^ cfg_par_typ)) &&
          (par_err_cnt != '1))
        par_err_cnt <= par_err_cnt + ERR_ONE;
      if (chk_stop && !sampled_bit && (stp_err_cnt != '1))
        stp_err_cnt <= stp_err_cnt + ERR_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fsm
// Directed bench for uart_rx_fsm. A small behavioural data_sampling model turns
// RX_IN into sampled_bit; good frames push their byte into a scoreboard queue
// and an independent monitor pops and compares on every data_valid strobe.
// -----------------------------------------------------------------------------
module tb_uart_rx_fsm;
  import uart_rx_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       sampled_bit;
  logic       dat_samp_en;
  logic [5:0] edge_cnt;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
`ifdef UART_RX_ERR_CNT_EN
  logic [1:0] par_err_cnt;
  logic [1:0] stp_err_cnt;
`endif

  uart_rx_fsm #(.DATA_W(8), .ERR_W(2)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .prescale    (prescale),
    .PAR_EN      (PAR_EN),
    .PAR_TYP     (PAR_TYP),
    .sampled_bit (sampled_bit),
    .dat_samp_en (dat_samp_en),
    .edge_cnt    (edge_cnt),
    .P_DATA      (P_DATA),
    .data_valid  (data_valid),
    .par_err     (par_err),
    .stp_err     (stp_err)
`ifdef UART_RX_ERR_CNT_EN
    ,
    .par_err_cnt (par_err_cnt),
    .stp_err_cnt (stp_err_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  int cur_p = 8;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural data_sampling: three samples around mid-bit, majority
  // registered one cycle after the last sample.
  logic s0 = 1'b1, s1 = 1'b1;
  initial sampled_bit = 1'b1;
  always @(posedge CLK) begin
    if (dat_samp_en) begin
      if (int'(edge_cnt) == cur_p/2 - 1) s0 <= RX_IN;
      if (int'(edge_cnt) == cur_p/2)     s1 <= RX_IN;
      if (int'(edge_cnt) == cur_p/2 + 1)
        sampled_bit <= (s0 & s1) | (s0 & RX_IN) | (s1 & RX_IN);
    end
  end

  // Scoreboard monitor.
  logic prev_dv = 1'b0;
  always @(negedge CLK) begin
    if (data_valid) begin
      check("dv_one_cycle", {31'd0, prev_dv}, 32'd0);
      if (exp_q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
      else                   check("p_data", {24'd0, P_DATA}, {24'd0, exp_q.pop_front()});
    end
    prev_dv <= data_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; holds the line for one bit period of the bench's timing.
  task automatic send_bit(input logic b);
    RX_IN = b;
    repeat (cur_p) @(negedge CLK);
  endtask

  // disturb: scramble the configuration inputs after the start bit to prove
  // the DUT uses the values latched at start detection.
  task automatic send_frame(input logic [7:0] d, input logic [5:0] p, input logic pen,
                            input logic ptyp, input logic pbit, input logic sbit,
                            input logic disturb);
    prescale = p; PAR_EN = pen; PAR_TYP = ptyp; cur_p = int'(p);
    send_bit(1'b0);
    if (disturb) begin
      prescale = (p == PRESC_32) ? PRESC_8 : PRESC_32;
      PAR_EN   = ~pen;
      PAR_TYP  = ~ptyp;
    end
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (pen) send_bit(pbit);
    send_bit(sbit);
    RX_IN = 1'b1;
    prescale = p; PAR_EN = pen; PAR_TYP = ptyp;
    repeat (3) @(negedge CLK);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dat_samp_en"}, {31'd0, dat_samp_en}, 32'd0);
    check({tag, "_edge_cnt"},    {26'd0, edge_cnt},    32'd0);
    check({tag, "_p_data"},      {24'd0, P_DATA},      32'd0);
    check({tag, "_data_valid"},  {31'd0, data_valid},  32'd0);
    check({tag, "_par_err"},     {31'd0, par_err},     32'd0);
    check({tag, "_stp_err"},     {31'd0, stp_err},     32'd0);
  endtask

  initial begin
    RST = 1'b1; RX_IN = 1'b1; prescale = PRESC_8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    @(posedge CLK); @(negedge CLK);
    check_reset_outputs("reset");
`ifdef UART_RX_ERR_CNT_EN
    check("reset_par_err_cnt", {30'd0, par_err_cnt}, 32'd0);
    check("reset_stp_err_cnt", {30'd0, stp_err_cnt}, 32'd0);
`endif
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // 1: prescale 8, no parity, 0xA5, config scrambled mid-frame.
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, PRESC_8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("t1_par_err", {31'd0, par_err}, 32'd0);
    check("t1_stp_err", {31'd0, stp_err}, 32'd0);

    // 2: prescale 16, even parity, 0x3C (four ones -> parity bit 0).
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, PRESC_16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t2_good_par_err", {31'd0, par_err}, 32'd0);
    send_frame(8'h3C, PRESC_16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("t2_bad_par_err", {31'd0, par_err}, 32'd1);
    check("t2_bad_stp_err", {31'd0, stp_err}, 32'd0);
    check("t2_bad_p_data",  {24'd0, P_DATA},  32'h3C);
`ifdef UART_RX_ERR_CNT_EN
    check("t2_par_err_cnt", {30'd0, par_err_cnt}, 32'd1);
`endif

    // 3: prescale 32, stop bit low, then a good 0x11.
    send_frame(8'hC3, PRESC_32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t3_stp_err", {31'd0, stp_err}, 32'd1);
    check("t3_p_data",  {24'd0, P_DATA},  32'h3C);
`ifdef UART_RX_ERR_CNT_EN
    check("t3_stp_err_cnt", {30'd0, stp_err_cnt}, 32'd1);
`endif
    exp_q.push_back(8'h11);
    prescale = PRESC_32; PAR_EN = 1'b0; cur_p = 32;
    send_bit(1'b0);
    check("t3_flag_held", {31'd0, stp_err}, 32'd1);
    send_bit(1'b1);  // bit 0 of 0x11
    check("t3_stp_cleared", {31'd0, stp_err}, 32'd0);
    check("t3_par_cleared", {31'd0, par_err}, 32'd0);
    for (int i = 1; i < 8; i++) send_bit((i == 4) ? 1'b1 : 1'b0);
    send_bit(1'b1);
    RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    check("t3_good_stp_err", {31'd0, stp_err}, 32'd0);

    // 4: two-cycle glitch at prescale 16.
    prescale = PRESC_16; cur_p = 16;
    RX_IN = 1'b0;
    repeat (2) @(negedge CLK);
    RX_IN = 1'b1;
    check("t4_in_start", {31'd0, dat_samp_en}, 32'd1);
    repeat (20) @(negedge CLK);
    check("t4_back_idle", {31'd0, dat_samp_en}, 32'd0);
    check("t4_p_data",    {24'd0, P_DATA},      32'h11);
    check("t4_par_err",   {31'd0, par_err},     32'd0);
    check("t4_stp_err",   {31'd0, stp_err},     32'd0);

    // 5: reset in the middle of DATA, then 0x5A with odd parity (bit = 1).
    PAR_EN = 1'b0;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    check("t5_in_frame", {31'd0, dat_samp_en}, 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    check_reset_outputs("t5_rst");
`ifdef UART_RX_ERR_CNT_EN
    check("t5_par_err_cnt", {30'd0, par_err_cnt}, 32'd0);
    check("t5_stp_err_cnt", {30'd0, stp_err_cnt}, 32'd0);
`endif
    RST = 1'b0; RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, PRESC_16, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("t5_par_err", {31'd0, par_err}, 32'd0);

`ifdef UART_RX_ERR_CNT_EN
    // 6: five parity-error frames saturate a 2-bit counter at 3.
    for (int k = 0; k < 5; k++)
      send_frame(8'h01, PRESC_8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t6_par_err_cnt", {30'd0, par_err_cnt}, 32'd3);
    check("t6_stp_err_cnt", {30'd0, stp_err_cnt}, 32'd0);
    check("t6_p_data",      {24'd0, P_DATA},      32'h5A);
`endif

    repeat (5) @(negedge CLK);
    check("sb_drain", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
